// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-entry valid/ready output buffer.
// Mid-bit sampling from a synchronized line; frame-error and overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       nreset_i,
    input  logic       rx_i,
    output logic [7:0] rx_data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t        state;
    logic          rx_m;
    logic          rx_s;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
        end
    end

    // frame FSM plus output buffer; flags are single-cycle registered pulses
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            rx_data_o   <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // a byte being accepted this edge frees the slot
                            if (!valid_o || ready_i) begin
                                rx_data_o <= shift;
                                valid_o   <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            frame_err_o <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at CLKS_PER_BIT = 16.
// Bytes sent are queued as expected; accepted bytes are compared in order.
module tb_uart_rx;

    localparam int CPB   = 16;
    localparam int CLK_T = 100;
    localparam int BIT_T = CPB * CLK_T;

    logic       clk;
    logic       nreset_i;
    logic       rx_i;
    logic [7:0] rx_data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int both_cnt = 0;
    int rd_idx   = 0;
    int fe0;
    int ov0;
    int got0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i      (clk),
        .nreset_i   (nreset_i),
        .rx_i       (rx_i),
        .rx_data_o  (rx_data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    initial begin
        clk = 1'b0;
        forever #(CLK_T / 2) clk = ~clk;
    end

    // record handshakes and flag pulses away from the active edge
    always @(negedge clk) begin
        if (valid_o && ready_i) got_q.push_back(rx_data_o);
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
        if (frame_err_o && overrun_o) both_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag);
        logic [7:0] e;
        int n;
        n = 0;
        while (got_q.size() <= rd_idx && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (got_q.size() <= rd_idx) begin
            chk({tag, "_timeout"}, got_q.size(), rd_idx + 1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, got_q[rd_idx], e);
            rd_idx++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int bit_t);
        rx_i = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            #(bit_t);
        end
        rx_i = stop;
        #(bit_t);
    endtask

    task automatic align;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rx_i     = 1'b1;
        ready_i  = 1'b0;
        nreset_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", rx_data_o, 0);
        chk("rst_fe", frame_err_o, 0);
        chk("rst_ov", overrun_o, 0);
        nreset_i = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // single frame with exact latency: 2 sync + 1 detect + 8 + 144
        exp_q.push_back(8'h95);
        fork
            send_frame(8'h95, 1'b1, BIT_T);
            begin
                repeat (154) @(posedge clk);
                @(negedge clk);
                chk("lat_pre", valid_o, 0);
                @(posedge clk);
                @(negedge clk);
                chk("lat_valid", valid_o, 1);
                chk("lat_data", rx_data_o, 8'h95);
            end
        join
        chk("single_fe", fe_cnt, 0);
        chk("single_ov", ov_cnt, 0);
        ready_i = 1'b1;
        align();
        ready_i = 1'b0;
        chk("ack_valid", valid_o, 0);
        check_next("single_byte");

        // back-to-back frames, consumer always ready
        ready_i = 1'b1;
        exp_q.push_back(8'h95);
        exp_q.push_back(8'h14);
        send_frame(8'h95, 1'b1, BIT_T);
        send_frame(8'h14, 1'b1, BIT_T);
        check_next("b2b_first");
        check_next("b2b_second");
        chk("b2b_fe", fe_cnt, 0);
        chk("b2b_ov", ov_cnt, 0);

        // 3-cycle glitch must not produce a byte or a flag
        align();
        rx_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("glitch_valid", valid_o, 0);
        chk("glitch_nobyte", got_q.size(), rd_idx);
        chk("glitch_fe", fe_cnt, 0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, BIT_T);
        check_next("after_glitch");

        // bad stop bit then a long break
        fe0  = fe_cnt;
        got0 = got_q.size();
        align();
        send_frame(8'h3C, 1'b0, BIT_T);
        #(40 * BIT_T);
        chk("ferr_pulses", fe_cnt - fe0, 1);
        chk("ferr_nobyte", got_q.size(), got0);
        chk("ferr_valid", valid_o, 0);
        rx_i = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1, BIT_T);
        check_next("after_ferr");
        chk("ferr_total", fe_cnt - fe0, 1);

        // overrun: second frame dropped while buffer is held
        ready_i = 1'b0;
        ov0 = ov_cnt;
        fe0 = fe_cnt;
        align();
        send_frame(8'h11, 1'b1, BIT_T);
        send_frame(8'h22, 1'b1, BIT_T);
        repeat (10) @(posedge clk);
        #1;
        chk("ovr_pulses", ov_cnt - ov0, 1);
        chk("ovr_data", rx_data_o, 8'h11);
        chk("ovr_valid", valid_o, 1);
        chk("ovr_fe", fe_cnt - fe0, 0);
        exp_q.push_back(8'h11);
        ready_i = 1'b1;
        align();
        ready_i = 1'b0;
        check_next("ovr_kept");

        // accept old byte on the very edge the new one loads
        align();
        send_frame(8'h33, 1'b1, BIT_T);
        repeat (10) @(posedge clk);
        #1;
        chk("held_data", rx_data_o, 8'h33);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        fork
            send_frame(8'h44, 1'b1, BIT_T);
            begin
                repeat (154) @(posedge clk);
                #1;
                ready_i = 1'b1;
                @(posedge clk);
                #1;
                ready_i = 1'b0;
            end
        join
        chk("swap_valid", valid_o, 1);
        chk("swap_data", rx_data_o, 8'h44);
        chk("swap_no_ov", ov_cnt - ov0, 1);
        check_next("swap_old");
        ready_i = 1'b1;
        align();
        ready_i = 1'b0;
        check_next("swap_new");

        // asynchronous reset in the middle of data bit 4
        align();
        send_frame(8'h66, 1'b1, BIT_T);
        repeat (10) @(posedge clk);
        #1;
        chk("pre_rst_valid", valid_o, 1);
        align();
        fork
            send_frame(8'h77, 1'b1, BIT_T);
            begin
                #(5 * BIT_T + 750);
                nreset_i = 1'b0;
                #10;
                chk("arst_valid", valid_o, 0);
                chk("arst_data", rx_data_o, 0);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        nreset_i = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_valid", valid_o, 0);
        chk("post_rst_nobyte", got_q.size(), rd_idx);
        ready_i = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, BIT_T * 104 / 100);
        check_next("slow_baud");

        repeat (20) @(posedge clk);
        #1;
        chk("no_extra", got_q.size(), rd_idx);
        chk("no_both", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
